// File: rtl/periph_bus_pkg.sv
// Shared encodings and lane helpers for the 16-bit big-endian peripheral bus.
// Byte lane [15:8] belongs to the even address, [7:0] to the odd address.
package periph_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_WORD = 2'd1;
    localparam logic [1:0] SZ_LONG = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        GAP
    } state_t;

    // {uds, lds} for the access; everything wider than a byte uses both lanes
    function automatic logic [1:0] lane_sel(input logic [1:0] size, input logic a0);
        if (size == SZ_BYTE) begin
            return a0 ? 2'b01 : 2'b10;
        end
        return 2'b11;
    endfunction

    // Bus write data for the first (or only) bus cycle of an access
    function automatic logic [15:0] first_wlane(input logic [1:0] size, input logic a0,
                                                input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return a0 ? {8'h00, wdata[7:0]} : {wdata[7:0], 8'h00};
            SZ_LONG: return wdata[31:16];
            default: return wdata[15:0];
        endcase
    endfunction

endpackage

// File: rtl/periph_bus_master_timeout.sv
// Strobe watchdog: counts STROBE cycles without ack; expired is combinational.
// Latency 0 (expired asserts in the cycle the count would reach TIMEOUT); no backpressure.
// Cleared on every STROBE entry.
module bus_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 16'd1;
        end
    end

    // Fires on the TIMEOUT-th unacknowledged strobe cycle, so strobes last exactly TIMEOUT cycles
    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/periph_bus_master.sv
// Peripheral bus initiator: one byte/word/long request -> one or two ack-handshaked bus cycles.
// Latency 3 cycles accept->rsp_valid (6 for long) with a zero-wait responder; 1 cycle on alignment error.
// req_ready only in IDLE; rsp_valid is a single pulse with no backpressure.
module periph_bus_master
    import periph_bus_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_rw,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [15:0]       bus_data_write,
    input  logic [15:0]       bus_data_read,
    output logic              bus_uds,
    output logic              bus_lds,
    output logic              bus_rw,
    input  logic              bus_ack
);

    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic              rw_q, rw_nxt;
    logic [1:0]        size_q, size_nxt;
    logic [31:0]       wdata_q, wdata_nxt;
    logic              half_q, half_nxt;
    logic              tout_q, tout_nxt;
    logic [31:0]       rdata_q, rdata_nxt;

    logic              rsp_valid_nxt, rsp_err_nxt;
    logic [31:0]       rsp_rdata_nxt;
    logic [ADDR_W-1:0] bus_addr_nxt;
    logic [15:0]       bus_data_write_nxt;
    logic              bus_uds_nxt, bus_lds_nxt, bus_rw_nxt;

    logic              acc_err;
    logic              cnt_clear;
    logic              cnt_en;
    logic              expired;

    assign req_ready = (state == IDLE) && !reset;
    assign acc_err   = (req_size == SZ_RSVD) || ((req_size != SZ_BYTE) && req_addr[0]);
    assign cnt_en    = (state == STROBE) && !bus_ack;

    bus_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .expired(expired)
    );

    always_comb begin
        state_nxt          = state;
        addr_nxt           = addr_q;
        rw_nxt             = rw_q;
        size_nxt           = size_q;
        wdata_nxt          = wdata_q;
        half_nxt           = half_q;
        tout_nxt           = tout_q;
        rdata_nxt          = rdata_q;
        rsp_valid_nxt      = 1'b0;
        rsp_err_nxt        = 1'b0;
        rsp_rdata_nxt      = 32'h0;
        bus_addr_nxt       = bus_addr;
        bus_data_write_nxt = bus_data_write;
        bus_uds_nxt        = bus_uds;
        bus_lds_nxt        = bus_lds;
        bus_rw_nxt         = bus_rw;
        cnt_clear          = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    addr_nxt  = req_addr;
                    rw_nxt    = req_rw;
                    size_nxt  = req_size;
                    wdata_nxt = req_wdata;
                    half_nxt  = 1'b0;
                    tout_nxt  = 1'b0;
                    rdata_nxt = 32'h0;
                    if (acc_err) begin
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                    end else begin
                        state_nxt                  = STROBE;
                        cnt_clear                  = 1'b1;
                        {bus_uds_nxt, bus_lds_nxt} = lane_sel(req_size, req_addr[0]);
                        bus_addr_nxt               = req_addr;
                        bus_rw_nxt                 = req_rw;
                        bus_data_write_nxt         = first_wlane(req_size, req_addr[0], req_wdata);
                    end
                end
            end

            STROBE: begin
                if (bus_ack) begin
                    case (size_q)
                        SZ_BYTE: rdata_nxt = {24'h0, addr_q[0] ? bus_data_read[7:0]
                                                               : bus_data_read[15:8]};
                        SZ_WORD: rdata_nxt = {16'h0, bus_data_read};
                        default: begin
                            if (half_q) begin
                                rdata_nxt[15:0] = bus_data_read;
                            end else begin
                                rdata_nxt[31:16] = bus_data_read;
                            end
                        end
                    endcase
                    bus_uds_nxt = 1'b0;
                    bus_lds_nxt = 1'b0;
                    bus_rw_nxt  = 1'b1;
                    state_nxt   = GAP;
                end else if (expired) begin
                    tout_nxt    = 1'b1;
                    bus_uds_nxt = 1'b0;
                    bus_lds_nxt = 1'b0;
                    bus_rw_nxt  = 1'b1;
                    state_nxt   = GAP;
                end
            end

            GAP: begin
                // A timed-out first half suppresses the second half of a long
                if ((size_q == SZ_LONG) && !half_q && !tout_q) begin
                    half_nxt           = 1'b1;
                    state_nxt          = STROBE;
                    cnt_clear          = 1'b1;
                    bus_uds_nxt        = 1'b1;
                    bus_lds_nxt        = 1'b1;
                    bus_addr_nxt       = addr_q + ADDR_W'(2);
                    bus_rw_nxt         = rw_q;
                    bus_data_write_nxt = wdata_q[15:0];
                end else begin
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = tout_q;
                    rsp_rdata_nxt = (tout_q || !rw_q) ? 32'h0 : rdata_q;
                    state_nxt     = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            addr_q         <= '0;
            rw_q           <= 1'b1;
            size_q         <= SZ_BYTE;
            wdata_q        <= 32'h0;
            half_q         <= 1'b0;
            tout_q         <= 1'b0;
            rdata_q        <= 32'h0;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_rdata      <= 32'h0;
            bus_addr       <= '0;
            bus_data_write <= 16'h0;
            bus_uds        <= 1'b0;
            bus_lds        <= 1'b0;
            bus_rw         <= 1'b1;
        end else begin
            state          <= state_nxt;
            addr_q         <= addr_nxt;
            rw_q           <= rw_nxt;
            size_q         <= size_nxt;
            wdata_q        <= wdata_nxt;
            half_q         <= half_nxt;
            tout_q         <= tout_nxt;
            rdata_q        <= rdata_nxt;
            rsp_valid      <= rsp_valid_nxt;
            rsp_err        <= rsp_err_nxt;
            rsp_rdata      <= rsp_rdata_nxt;
            bus_addr       <= bus_addr_nxt;
            bus_data_write <= bus_data_write_nxt;
            bus_uds        <= bus_uds_nxt;
            bus_lds        <= bus_lds_nxt;
            bus_rw         <= bus_rw_nxt;
        end
    end

endmodule

// File: tb/tb_periph_bus_master.sv
// Bench for periph_bus_master: responder with programmable ack delay, request-level
// reference model that lays out the expected per-cycle bus/response timeline.
module tb_periph_bus_master;

    localparam int TO   = 8;
    localparam int MAXC = 16384;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_addr = 8'h0;
    logic        req_rw = 1'b1;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  bus_addr;
    logic [15:0] bus_data_write;
    logic [15:0] bus_data_read = 16'h0;
    logic        bus_uds;
    logic        bus_lds;
    logic        bus_rw;
    logic        bus_ack = 1'b0;

    always #5 clk = ~clk;

    periph_bus_master #(.ADDR_W(8), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_rw        (req_rw),
        .req_size      (req_size),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .bus_addr      (bus_addr),
        .bus_data_write(bus_data_write),
        .bus_data_read (bus_data_read),
        .bus_uds       (bus_uds),
        .bus_lds       (bus_lds),
        .bus_rw        (bus_rw),
        .bus_ack       (bus_ack)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected timeline, indexed by cycle number (the period following edge number cyc)
    logic        exp_ready [MAXC];
    logic [1:0]  exp_strb  [MAXC];
    logic [7:0]  exp_addr  [MAXC];
    logic        exp_rw    [MAXC];
    logic [15:0] exp_wd    [MAXC];
    logic        exp_rv    [MAXC];
    logic        exp_err   [MAXC];
    logic [31:0] exp_rd    [MAXC];

    logic [7:0] ref_mem [256];

    // Responder: registered ack after rs_delay+1 sampled strobe cycles; rs_delay<0 never acks
    logic [7:0] mem [256];
    logic       mem_ready = 1'b0;
    int         rs_delay = 0;
    int         rs_cnt = 0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
            mem_ready = 1'b1;
        end
        if (bus_uds || bus_lds) begin
            if (rs_delay >= 0 && rs_cnt >= rs_delay) begin
                bus_ack       <= 1'b1;
                bus_data_read <= {mem[{bus_addr[7:1], 1'b0}], mem[{bus_addr[7:1], 1'b1}]};
                if (!bus_rw) begin
                    if (bus_uds) mem[{bus_addr[7:1], 1'b0}] = bus_data_write[15:8];
                    if (bus_lds) mem[{bus_addr[7:1], 1'b1}] = bus_data_write[7:0];
                end
            end else begin
                bus_ack       <= 1'b0;
                bus_data_read <= 16'($urandom);
            end
            rs_cnt <= rs_cnt + 1;
        end else begin
            rs_cnt        <= 0;
            bus_ack       <= 1'b0;
            bus_data_read <= 16'($urandom);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready[cyc]));
            chk("strobes", 32'({bus_uds, bus_lds}), 32'(exp_strb[cyc]));
            if (exp_strb[cyc] != 2'b00) begin
                chk("bus_addr", 32'(bus_addr), 32'(exp_addr[cyc]));
                chk("bus_rw", 32'(bus_rw), 32'(exp_rw[cyc]));
                if (!exp_rw[cyc]) begin
                    if (exp_strb[cyc][1]) chk("wdata_hi", 32'(bus_data_write[15:8]), 32'(exp_wd[cyc][15:8]));
                    if (exp_strb[cyc][0]) chk("wdata_lo", 32'(bus_data_write[7:0]), 32'(exp_wd[cyc][7:0]));
                end
            end else begin
                chk("bus_rw_idle", 32'(bus_rw), 32'h1);
            end
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv[cyc]));
            if (exp_rv[cyc]) begin
                chk("rsp_err", 32'(rsp_err), 32'(exp_err[cyc]));
                chk("rsp_rdata", rsp_rdata, exp_rd[cyc]);
            end
        end
    end

    // Request-level model: error check, per-half strobe windows, response cycle and data
    task automatic plan(input int A, input logic [1:0] sz, input logic [7:0] a, input logic rw,
                        input logic [31:0] wd, input int d);
        logic [7:0]  a1, a2, a3;
        logic [31:0] val;
        logic [1:0]  strb;
        logic [15:0] wl;
        int          nh, s, p;
        bit          to;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        a3 = a + 8'd3;
        if (sz == 2'd3 || (sz != 2'd0 && a[0])) begin
            exp_rv[A+1]  = 1'b1;
            exp_err[A+1] = 1'b1;
            exp_rd[A+1]  = 32'h0;
            return;
        end
        to   = (d < 0) || (d + 2 > TO);
        s    = to ? TO : d + 2;
        nh   = to ? 1 : ((sz == 2'd2) ? 2 : 1);
        strb = (sz == 2'd0) ? (a[0] ? 2'b01 : 2'b10) : 2'b11;
        p    = A + 1;
        for (int h = 0; h < nh; h++) begin
            if (sz == 2'd0) wl = a[0] ? {8'h00, wd[7:0]} : {wd[7:0], 8'h00};
            else if (sz == 2'd2) wl = (h == 0) ? wd[31:16] : wd[15:0];
            else wl = wd[15:0];
            for (int k = 0; k < s; k++) begin
                exp_strb[p+k]  = strb;
                exp_addr[p+k]  = (h == 0) ? a : a2;
                exp_rw[p+k]    = rw;
                exp_wd[p+k]    = wl;
                exp_ready[p+k] = 1'b0;
            end
            exp_ready[p+s] = 1'b0;
            p = p + s + 1;
        end
        case (sz)
            2'd0:    val = {24'h0, ref_mem[a]};
            2'd1:    val = {16'h0, ref_mem[a], ref_mem[a1]};
            default: val = {ref_mem[a], ref_mem[a1], ref_mem[a2], ref_mem[a3]};
        endcase
        exp_rv[p]  = 1'b1;
        exp_err[p] = to;
        exp_rd[p]  = (to || !rw) ? 32'h0 : val;
        if (!to && !rw) begin
            case (sz)
                2'd0: ref_mem[a] = wd[7:0];
                2'd1: begin ref_mem[a] = wd[15:8]; ref_mem[a1] = wd[7:0]; end
                default: begin
                    ref_mem[a]  = wd[31:24];
                    ref_mem[a1] = wd[23:16];
                    ref_mem[a2] = wd[15:8];
                    ref_mem[a3] = wd[7:0];
                end
            endcase
        end
    endtask

    // Called in an idle cycle, #1 after the edge; returns #1 after the edge following the response
    task automatic do_req(input logic [1:0] sz, input logic [7:0] a, input logic rw,
                          input logic [31:0] wd, input int d,
                          output logic [31:0] rd, output logic er, output int lat);
        int A;
        bit got;
        A         = cyc;
        rs_delay  = d;
        req_size  = sz;
        req_addr  = a;
        req_rw    = rw;
        req_wdata = wd;
        req_valid = 1'b1;
        plan(A, sz, a, rw, wd, d);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 8'($urandom);
        req_size  = 2'($urandom);
        req_rw    = 1'($urandom);
        req_wdata = $urandom;
        got = 1'b0;
        rd  = 32'h0;
        er  = 1'b0;
        lat = -1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                rd  = rsp_rdata;
                er  = rsp_err;
                lat = cyc - A - 1;
            end
        end
        chk("rsp_arrives", 32'(got), 32'h1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          A, d;
        logic [1:0]  sz;
        logic [7:0]  a;
        logic        rw;

        for (int i = 0; i < MAXC; i++) begin
            exp_ready[i] = 1'b1;
            exp_strb[i]  = 2'b00;
            exp_addr[i]  = 8'h0;
            exp_rw[i]    = 1'b1;
            exp_wd[i]    = 16'h0;
            exp_rv[i]    = 1'b0;
            exp_err[i]   = 1'b0;
            exp_rd[i]    = 32'h0;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_strobes", 32'({bus_uds, bus_lds}), 32'h0);
        chk("rst_bus_rw", 32'(bus_rw), 32'h1);
        chk("rst_bus_addr", 32'(bus_addr), 32'h0);
        chk("rst_bus_wdata", 32'(bus_data_write), 32'h0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases with hand-computed results
        do_req(2'd1, 8'h06, 1'b0, 32'h0000_1234, 0, rd, er, lat);
        chk("wr_word_err", 32'(er), 32'h0);
        chk("wr_word_lat", 32'(lat), 32'd3);
        do_req(2'd1, 8'h06, 1'b1, 32'h0, 0, rd, er, lat);
        chk("rd_word_data", rd, 32'h0000_1234);
        chk("rd_word_lat", 32'(lat), 32'd3);
        do_req(2'd2, 8'h04, 1'b0, 32'hDEAD_BEEF, 0, rd, er, lat);
        chk("wr_long_lat", 32'(lat), 32'd6);
        do_req(2'd2, 8'h04, 1'b1, 32'h0, 0, rd, er, lat);
        chk("rd_long_data", rd, 32'hDEAD_BEEF);
        chk("rd_long_lat", 32'(lat), 32'd6);
        do_req(2'd1, 8'h06, 1'b0, 32'h0000_1234, 0, rd, er, lat);
        do_req(2'd0, 8'h07, 1'b0, 32'h0000_005A, 0, rd, er, lat);
        chk("wr_byte_lat", 32'(lat), 32'd3);
        do_req(2'd0, 8'h06, 1'b1, 32'h0, 0, rd, er, lat);
        chk("rd_byte_even", rd, 32'h0000_0012);
        do_req(2'd0, 8'h07, 1'b1, 32'h0, 0, rd, er, lat);
        chk("rd_byte_odd", rd, 32'h0000_005A);
        do_req(2'd1, 8'h03, 1'b1, 32'h0, 0, rd, er, lat);
        chk("misalign_err", 32'(er), 32'h1);
        chk("misalign_rdata", rd, 32'h0);
        chk("misalign_lat", 32'(lat), 32'd0);
        do_req(2'd3, 8'h04, 1'b1, 32'h0, 0, rd, er, lat);
        chk("rsvd_err", 32'(er), 32'h1);
        do_req(2'd1, 8'h06, 1'b1, 32'h0, -1, rd, er, lat);
        chk("tout_word_err", 32'(er), 32'h1);
        chk("tout_word_rdata", rd, 32'h0);
        chk("tout_word_lat", 32'(lat), 32'd9);
        do_req(2'd2, 8'h10, 1'b1, 32'h0, -1, rd, er, lat);
        chk("tout_long_err", 32'(er), 32'h1);
        chk("tout_long_lat", 32'(lat), 32'd9);
        do_req(2'd1, 8'h06, 1'b1, 32'h0, 6, rd, er, lat);
        chk("ack_at_limit_err", 32'(er), 32'h0);
        chk("ack_at_limit_data", rd, 32'h0000_125A);
        do_req(2'd1, 8'h06, 1'b1, 32'h0, 7, rd, er, lat);
        chk("ack_late_err", 32'(er), 32'h1);
        do_req(2'd2, 8'hFE, 1'b0, 32'hA1B2_C3D4, 1, rd, er, lat);
        do_req(2'd2, 8'hFE, 1'b1, 32'h0, 0, rd, er, lat);
        chk("long_wrap_data", rd, 32'hA1B2_C3D4);

        // Reset pulsed while the first half of a long read is strobing
        A         = cyc;
        rs_delay  = 2;
        req_size  = 2'd2;
        req_addr  = 8'h20;
        req_rw    = 1'b1;
        req_valid = 1'b1;
        plan(A, 2'd2, 8'h20, 1'b1, 32'h0, 2);
        for (int k = A + 3; k < A + 40; k++) begin
            exp_ready[k] = 1'b1;
            exp_strb[k]  = 2'b00;
            exp_rv[k]    = 1'b0;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        chk("post_rst_strobes", 32'({bus_uds, bus_lds}), 32'h0);
        repeat (20) @(posedge clk);
        #1;
        do_req(2'd1, 8'h06, 1'b1, 32'h0, 0, rd, er, lat);
        chk("post_rst_word_err", 32'(er), 32'h0);
        chk("post_rst_word_lat", 32'(lat), 32'd3);

        // Randomized traffic, checked every cycle against the model timeline
        for (int n = 0; n < 250 && cyc < MAXC - 100; n++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 8'($urandom);
            if (sz != 2'd0 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
            rw = 1'($urandom);
            case ($urandom_range(0, 19))
                14, 15:  d = 6;
                16:      begin d = 7; rw = 1'b1; end
                17:      d = -1;
                18, 19:  d = 0;
                default: d = int'($urandom_range(0, 3));
            endcase
            do_req(sz, a, rw, $urandom, d, rd, er, lat);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/periph_bus_master.md
Name: periph_bus_master

Overview:
- Initiator for the 16-bit peripheral bus (addr/uds/lds/rw/ack, 68000-style big-endian byte lanes) that the timer and other peripherals respond on.
- Accepts a single byte/word/long request from an internal client (debug loader, DMA or CPU bridge) and issues one or two bus cycles.
- Handles the ack handshake, timeout and response.
- Sits between the client and the peripheral decode fabric.

Parameters:
- ADDR_W, 8, width of req_addr and bus_addr.
- TIMEOUT, 255, maximum cycles a strobe is held without ack before abort (1..65535).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; the request transfers when req_valid && req_ready
- req_addr  in  ADDR_W  byte address
- req_rw  in  1  1=read, 0=write
- req_size  in  2  0=byte, 1=word, 2=long, 3=reserved
- req_wdata  in  32  write data, right-aligned (byte in [7:0], word in [15:0])
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  32  read data, right-aligned and zero-extended; 0 on error or write
- rsp_err  out  1  qualified by rsp_valid: misaligned, reserved size or timeout
- bus_addr  out  ADDR_W  bus address
- bus_data_write  out  16  write data
- bus_data_read  in  16  responder read data, valid while bus_ack=1
- bus_uds  out  1  upper byte strobe (even address, data [15:8])
- bus_lds  out  1  lower byte strobe (odd address, data [7:0])
- bus_rw  out  1  1=read; idles at 1
- bus_ack  in  1  responder acknowledge

Behaviour:
- Reset values: req_ready=0 during reset, then 1. rsp_valid=0, rsp_rdata=0, rsp_err=0, bus_uds=0, bus_lds=0, bus_rw=1, bus_addr=0, bus_data_write=0.
- States:
  - IDLE: req_ready=1, strobes low, bus_ack ignored.
  - STROBE: strobes, addr and rw driven; waiting for ack.
  - GAP: one cycle with strobes low and bus_ack ignored. This absorbs the repeat ack the registered responder produces for the last cycle it saw the strobes.
  - RESP: not a separate state. rsp_valid is registered on the GAP exit edge.
- Acceptance latches addr, rw, size and wdata. Later req changes are ignored.
- Alignment check at accept:
  - size 3 → error.
  - word or long with addr[0]=1 → error.
  - On error: no bus cycle; rsp_valid with rsp_err=1 on the next cycle, then IDLE.
- Byte access: even addr → uds only, data lane [15:8]; odd addr → lds only, data lane [7:0]. Read byte is taken from that lane into rsp_rdata[7:0].
- Word access: uds and lds together; bus_data_write = wdata[15:0]; rsp_rdata[15:0] = bus_data_read.
- Long access: first cycle at addr carries the high word (wdata[31:16], read into rdata[31:16]). Second cycle at addr+2 (wraps mod 2^ADDR_W) carries the low word. Each cycle is followed by GAP.
- Transitions:
  - STROBE with bus_ack=1: latch bus_data_read, strobes low, go to GAP.
  - GAP: if another long half is pending → STROBE; else pulse rsp_valid and go to IDLE.
- Latency against a zero-wait responder (ack registered one cycle after strobes): rsp_valid is high 3 cycles after the accept edge for byte/word and 6 cycles for long. Strobes are high for exactly 2 cycles per half.
- Timeout:
  - Counter clears on STROBE entry and increments each STROBE cycle without ack.
  - When it reaches TIMEOUT: strobes low, go to GAP, then rsp_err=1 and rsp_rdata=0.
  - A pending second long half is not issued. For a long write, the first half may already have been written.
- Ack seen in the same cycle the count hits TIMEOUT: ack wins, no error.
- bus_ack high in IDLE or GAP: ignored.
- Reset mid-operation: next cycle strobes low, bus_rw=1, IDLE, no rsp_valid for the aborted request.

Decomposition:
- Package periph_bus_pkg: size encodings (SZ_BYTE=0, SZ_WORD=1, SZ_LONG=2), state encoding (IDLE, STROBE, GAP), and a lane-select function (size, addr[0]) → {uds, lds}.
- Sub-module bus_timeout_cnt (clear, enable, parameter TIMEOUT → expired) is natural. Everything else is in the top FSM.

Test Plan:
- Timer responder model; write word 0x1234 to addr 0x06, then word read from 0x06 → rsp_rdata=0x00001234, rsp_err=0, rsp_valid 3 cycles after accept, uds and lds high for 2 cycles.
- Long write 0xDEADBEEF to addr 0x04, then long read from 0x04 → bus writes 0xDEAD@0x04 and 0xBEEF@0x06, each followed by a strobe-low GAP; read returns 0xDEADBEEF after 6 cycles.
- Byte write 0x5A to addr 0x07 → only lds asserted, bus_data_write[7:0]=0x5A. Byte read from 0x06 (cmp=0x1234) → rsp_rdata=0x00000012.
- Word read at addr 0x03, and size=3 → no strobes, rsp_valid the next cycle with rsp_err=1 and rsp_rdata=0.
- Responder holds ack low, TIMEOUT=8 → strobes high for exactly 8 cycles, then rsp_err=1. For a long, the second half is never issued. Repeat with ack arriving on cycle 8 → no error.
- reset pulsed while in STROBE of a long read → strobes low on the next cycle, no rsp_valid, req_ready=1 after reset; a following word read completes normally.
